regfile_debug_dumper: RTL

//  Master for the register file debug read port (read_address_debug / clock_debug / data_out_debug).
//  On a start pulse it sweeps an address range, strobes the debug clock once per entry and

---
 rtl/regfile_debug_dumper_pkg.sv | 20 ++
 rtl/regfile_debug_dumper_if.sv | 31 +++
 rtl/regfile_debug_dumper.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_debug_dumper_pkg.sv
// Shared definitions for the register file debug dumper. The register
// file and the pipeline use the same width constants.
package regfile_debug_dumper_pkg;

    // Register file geometry shared across the core
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    // Settle counter width, enough for settle periods of up to 15 cycles
    localparam int SETTLE_CNT_W = 4;

    // Dumper FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_OUTPUT = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage : regfile_debug_dumper_pkg

// File: rtl/regfile_debug_dumper_if.sv
// Valid/ready word stream carrying a register index and its captured value
// from the dumper to a display or UART sink.
interface regfile_debug_dumper_if
    import regfile_debug_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
);

    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;

    // Dumper side: produces words
    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    // Sink side: consumes words
    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );

endinterface : regfile_debug_dumper_if

// File: rtl/regfile_debug_dumper.sv
// Register file debug dumper. On a start request it walks an inclusive,
// wrapping index range, fires one registered debug strobe per entry, waits
// the settle time, captures the debug read data and streams (index, value)
// words to a valid/ready sink. Everything runs in the core clock domain;
// clock_debug is a plain registered strobe.
module regfile_debug_dumper
    import regfile_debug_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH    = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH    = REG_DATA_WIDTH,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_address_debug,
    output logic                  clock_debug,
    input  logic [DATA_WIDTH-1:0] data_out_debug,
    regfile_debug_dumper_if.master out
);

    // Count value reached on the final settle cycle
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    logic [2:0]              state;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-1:0]   last_q;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic                    settle_last;
    logic                    out_xfer;
    logic                    at_last;
    logic [ADDR_WIDTH-1:0]   next_addr;

    // Capture happens on the edge that ends the final settle cycle
    assign settle_last = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
    // out_valid is always high in OUTPUT, so ready alone completes the transfer
    assign out_xfer    = (state == ST_OUTPUT) && out.out_ready;
    assign at_last     = (cur_addr == last_q);
    // Index increment wraps naturally at ADDR_WIDTH bits
    assign next_addr   = cur_addr + 1'b1;

    // Sweep sequencer: state, range registers, settle timer, debug port and status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            cur_addr           <= '0;
            last_q             <= '0;
            settle_cnt         <= '0;
            read_address_debug <= '0;
            clock_debug        <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr           <= first_addr;
                        last_q             <= last_addr;
                        read_address_debug <= first_addr;
                        busy               <= 1'b1;
                        state              <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // Address has had a full cycle to settle; raise the strobe
                    clock_debug <= 1'b1;
                    state       <= ST_STROBE;
                end
                ST_STROBE: begin
                    clock_debug <= 1'b0;
                    settle_cnt  <= '0;
                    state       <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_last) begin
                        settle_cnt <= '0;
                        state      <= ST_OUTPUT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    // Hold here under backpressure; no new strobe until the word leaves
                    if (out_xfer) begin
                        if (at_last) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            cur_addr           <= next_addr;
                            read_address_debug <= next_addr;
                            state              <= ST_SETUP;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output word register: load on capture, hold until the sink accepts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out.out_valid <= 1'b0;
            out.out_addr  <= '0;
            out.out_data  <= '0;
        end else if (settle_last) begin
            out.out_valid <= 1'b1;
            out.out_addr  <= cur_addr;
            out.out_data  <= data_out_debug;
        end else if (out_xfer) begin
            out.out_valid <= 1'b0;
        end
    end

endmodule : regfile_debug_dumper
